teclado_2: RTL and testbench

TECLADO_2 -- requirements
Module: teclado_2

---
 rtl/teclado_2_if.sv | 21 ++
 rtl/teclado_2.sv | 162 ++++++++++++++++
 tb/tb_teclado_2.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/teclado_2_if.sv
// Keypad bus: row sense in, column drive out, reference code and result flags.
// master drives the keypad/reference side, slave is the scanner.
interface teclado_2_if;
    logic [3:0]  in;
    logic [3:0]  out;
    logic [15:0] registrador_w;
    logic        teste;
    logic        teste1;
    logic        teste2;
    logic        mechuper;

    modport master (
        output in, registrador_w,
        input  out, teste, teste1, teste2, mechuper
    );

    modport slave (
        input  in, registrador_w,
        output out, teste, teste1, teste2, mechuper
    );
endinterface

// File: rtl/teclado_2.sv
// 4x4 matrix keypad scanner with debounce and a 4-digit code checker.
// One strobe per physical press; '#' compares the last four digits to registrador_w.
module teclado_2 #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CYC = 8
) (
    input  logic        clk,
    input  logic        reseta,
    teclado_2_if.slave  kp
);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);

    state_t          state_q, state_d;
    logic [3:0]      out_q, out_d;
    logic [3:0]      row_q, row_d;
    logic [SW-1:0]   scan_q, scan_d;
    logic [DW-1:0]   db_q, db_d;
    logic [15:0]     entry_q, entry_d;
    logic [2:0]      count_q, count_d;
    logic            teste_q, teste_d;
    logic            ok_q, ok_d;
    logic            bad_q, bad_d;
    logic            held_q, held_d;

    logic [1:0]      col_idx;
    logic [1:0]      row_idx;
    logic [3:0]      key_code;

    always_ff @(posedge clk or negedge reseta) begin
        if (!reseta) begin
            state_q <= SCAN;
            out_q   <= 4'b1110;
            row_q   <= 4'hF;
            scan_q  <= '0;
            db_q    <= '0;
            entry_q <= '0;
            count_q <= '0;
            teste_q <= 1'b0;
            ok_q    <= 1'b0;
            bad_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            row_q   <= row_d;
            scan_q  <= scan_d;
            db_q    <= db_d;
            entry_q <= entry_d;
            count_q <= count_d;
            teste_q <= teste_d;
            ok_q    <= ok_d;
            bad_q   <= bad_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        row_d   = row_q;
        scan_d  = scan_q;
        db_d    = db_q;
        entry_d = entry_q;
        count_d = count_q;
        teste_d = 1'b0;
        ok_d    = ok_q;
        bad_d   = bad_q;
        held_d  = held_q;

        case (out_q)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase

        // Lowest-index closed row wins when several keys share a column.
        row_idx = 2'd3;
        for (int i = 3; i >= 0; i--)
            if (!row_q[i]) row_idx = 2'(i);

        if (col_idx == 2'd3)
            key_code = 4'hA + {2'b00, row_idx};
        else if (row_idx == 2'd3)
            key_code = (col_idx == 2'd0) ? 4'hE : (col_idx == 2'd1) ? 4'h0 : 4'hF;
        else
            key_code = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx} + 4'd1;

        case (state_q)
            SCAN: begin
                if (kp.in == 4'hF) begin
                    if (scan_q == SW'(SCAN_DIV - 1)) begin
                        scan_d = '0;
                        out_d  = {out_q[2:0], out_q[3]};
                    end else begin
                        scan_d = scan_q + SW'(1);
                    end
                end else begin
                    row_d   = kp.in;
                    db_d    = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (kp.in != row_q) begin
                    scan_d  = '0;
                    state_d = SCAN;
                end else if (db_q == DW'(DEBOUNCE_CYC - 1)) begin
                    db_d    = db_q + DW'(1);
                    state_d = HELD;
                    teste_d = 1'b1;
                    held_d  = 1'b1;
                    ok_d    = 1'b0;
                    bad_d   = 1'b0;
                    if (key_code <= 4'h9) begin
                        entry_d = {entry_q[11:0], key_code};
                        count_d = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
                    end else if (key_code == 4'hE) begin
                        entry_d = '0;
                        count_d = '0;
                    end else if (key_code == 4'hF) begin
                        if (count_q == 3'd4 && entry_q == kp.registrador_w)
                            ok_d = 1'b1;
                        else
                            bad_d = 1'b1;
                        entry_d = '0;
                        count_d = '0;
                    end
                end else begin
                    db_d = db_q + DW'(1);
                end
            end
            HELD: begin
                if (kp.in == 4'hF) begin
                    db_d    = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (kp.in != 4'hF) begin
                    state_d = HELD;
                end else if (db_q == DW'(DEBOUNCE_CYC - 1)) begin
                    held_d  = 1'b0;
                    scan_d  = '0;
                    state_d = SCAN;
                end else begin
                    db_d = db_q + DW'(1);
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign kp.out      = out_q;
    assign kp.teste    = teste_q;
    assign kp.teste1   = ok_q;
    assign kp.teste2   = bad_q;
    assign kp.mechuper = held_q;
endmodule

// File: tb/tb_teclado_2.sv
// Bench for teclado_2: a keypad contact model closes the chosen key onto the
// driven column; a digit-queue model predicts the match/mismatch flags.
module tb_teclado_2;
    logic clk = 1'b0;
    logic reseta = 1'b0;

    teclado_2_if kp();

    teclado_2 #(.SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
        .clk    (clk),
        .reseta (reseta),
        .kp     (kp)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] LOWBIT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    string KEYMAP = "123A456B789C*0#D";

    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    logic       key_dn = 1'b0;
    logic [1:0] key_r  = 2'd0;
    logic [1:0] key_c  = 2'd0;

    int   mq[$];
    logic m1 = 1'b0;
    logic m2 = 1'b0;

    // Physical keypad: a closed key pulls its row low only while its column is driven.
    always_comb begin
        kp.in = 4'hF;
        if (key_dn && kp.out === LOWBIT[key_c]) kp.in = LOWBIT[key_r];
    end

    always @(negedge clk) if (kp.teste === 1'b1) pulses++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_key(input byte ch);
        int v;
        m1 = 1'b0;
        m2 = 1'b0;
        if (ch >= 8'd48 && ch <= 8'd57) begin
            mq.push_back(int'(ch) - 48);
            if (mq.size() > 4) void'(mq.pop_front());
        end else if (ch == 8'd42) begin
            mq.delete();
        end else if (ch == 8'd35) begin
            v = -1;
            if (mq.size() == 4) v = mq[0] * 4096 + mq[1] * 256 + mq[2] * 16 + mq[3];
            if (v == int'(kp.registrador_w)) m1 = 1'b1;
            else m2 = 1'b1;
            mq.delete();
        end
    endtask

    task automatic select_key(input byte ch);
        int idx;
        idx = 0;
        for (int i = 0; i < 16; i++) if (KEYMAP[i] == ch) idx = i;
        key_r = 2'(idx / 4);
        key_c = 2'(idx % 4);
    endtask

    task automatic press_key(input byte ch, input int extra);
        int p0;
        int n;
        select_key(ch);
        p0 = pulses;
        n = 0;
        key_dn = 1'b1;
        while (pulses == p0 && n < 200) begin tick(); n++; end
        chk($sformatf("strobe_wait_%c", ch), 32'(n < 200), 32'd1);
        repeat (extra) tick();
        key_dn = 1'b0;
        n = 0;
        while (kp.mechuper !== 1'b0 && n < 100) begin tick(); n++; end
        repeat (3) tick();
        model_key(ch);
        chk($sformatf("one_strobe_%c", ch), 32'(pulses - p0), 32'd1);
        chk($sformatf("flags_%c", ch), {29'd0, kp.teste1, kp.teste2, kp.mechuper}, {29'd0, m1, m2, 1'b0});
    endtask

    initial begin
        int p0;
        int n;
        int d[4];
        logic [15:0] code_v;

        kp.registrador_w = 16'h9999;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", {28'd0, kp.out}, 32'h0000000E);
        chk("reset_flags", {28'd0, kp.teste, kp.teste1, kp.teste2, kp.mechuper}, 32'd0);

        // Idle scan: each column held 4 clocks, then wrap.
        reseta = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("scan_k%0d", k), {28'd0, kp.out}, {28'd0, LOWBIT[2'((k / 4) % 4)]});
        end

        // Key 5: strobe exactly 8 cycles after detection, held 20 cycles.
        select_key("5");
        p0 = pulses;
        key_dn = 1'b1;
        n = 0;
        while (kp.out !== 4'b1101 && n < 50) begin tick(); n++; end
        chk("wait_col1", 32'(n < 50), 32'd1);
        tick();
        chk("det_no_strobe", {31'd0, kp.teste}, 32'd0);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("debounce_%0d", i), {31'd0, kp.teste}, 32'd0);
        end
        tick();
        chk("strobe_at_8", {30'd0, kp.teste, kp.mechuper}, 32'd3);
        tick();
        chk("strobe_one_cycle", {30'd0, kp.teste, kp.mechuper}, 32'd1);
        repeat (11) tick();
        chk("held_no_restrobe", 32'(pulses - p0), 32'd1);
        model_key("5");
        key_dn = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("release_hold_%0d", i), {31'd0, kp.mechuper}, 32'd1);
        end
        tick();
        chk("release_done", {31'd0, kp.mechuper}, 32'd0);

        // Glitch: 3 low cycles on column 0 must not strobe.
        select_key("1");
        n = 0;
        while (kp.out !== 4'b1110 && n < 50) begin tick(); n++; end
        p0 = pulses;
        key_dn = 1'b1;
        repeat (3) tick();
        key_dn = 1'b0;
        tick();
        chk("glitch_out_hold", {28'd0, kp.out}, 32'h0000000E);
        repeat (3) tick();
        chk("glitch_out_pre", {28'd0, kp.out}, 32'h0000000E);
        tick();
        chk("glitch_scan_resume", {28'd0, kp.out}, 32'h0000000D);
        repeat (12) tick();
        chk("glitch_no_strobe", 32'(pulses - p0), 32'd0);
        chk("glitch_not_held", {31'd0, kp.mechuper}, 32'd0);

        // Correct code.
        foreach (KEYMAP[i]) if (i < 0) $display("unused");
        press_key("9", 2); press_key("9", 0); press_key("9", 5); press_key("9", 1);
        press_key("#", 3);
        chk("code_match", {30'd0, kp.teste1, kp.teste2}, 32'd2);

        // Short code, then the next key clears the mismatch flag.
        press_key("1", 0); press_key("2", 4); press_key("#", 0);
        chk("short_code", {30'd0, kp.teste1, kp.teste2}, 32'd1);
        press_key("A", 2);
        chk("flag_cleared", {30'd0, kp.teste1, kp.teste2}, 32'd0);

        // Clear mid-entry.
        press_key("9", 0); press_key("9", 0); press_key("*", 1);
        press_key("9", 0); press_key("9", 2); press_key("9", 0); press_key("9", 0);
        press_key("#", 0);
        chk("clear_then_match", {30'd0, kp.teste1, kp.teste2}, 32'd2);

        // Reset while a key is held.
        select_key("3");
        key_dn = 1'b1;
        n = 0;
        while (kp.mechuper !== 1'b1 && n < 200) begin tick(); n++; end
        chk("held_before_reset", 32'(n < 200), 32'd1);
        reseta = 1'b0;
        #1;
        chk("midpress_reset", {28'd0, kp.out}, 32'h0000000E);
        chk("midpress_reset_flags", {28'd0, kp.teste, kp.teste1, kp.teste2, kp.mechuper}, 32'd0);
        key_dn = 1'b0;
        p0 = pulses;
        repeat (2) tick();
        reseta = 1'b1;
        mq.delete();
        m1 = 1'b0;
        m2 = 1'b0;
        tick();
        chk("post_reset_col0", {28'd0, kp.out}, 32'h0000000E);
        repeat (3) tick();
        chk("post_reset_col1", {28'd0, kp.out}, 32'h0000000D);
        chk("post_reset_no_strobe", 32'(pulses - p0), 32'd0);

        // Random keys and code attempts.
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int j = 0; j < 4; j++) d[j] = $urandom_range(0, 9);
                code_v = {4'(d[0]), 4'(d[1]), 4'(d[2]), 4'(d[3])};
                if ($urandom_range(0, 1) == 0)
                    kp.registrador_w = code_v;
                else
                    kp.registrador_w = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                                        4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                for (int j = 0; j < 4; j++) press_key(byte'(48 + d[j]), $urandom_range(0, 6));
                press_key("#", $urandom_range(0, 6));
            end else begin
                press_key(KEYMAP[$urandom_range(0, 15)], $urandom_range(0, 10));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
